stopwatch_uart_reporter: RTL

//   Sends stopwatch status and time to the PC as one ASCII line over an external uart_tx.

---
 rtl/stopwatch_pkg.sv | 30 +++
 rtl/bcd2ascii.sv | 22 ++
 rtl/stopwatch_uart_reporter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: reporter FSM states, ASCII line constants and
// the command codes decoded by stopwatch_cu.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT,
    NEXT
  } state_t;

  localparam int MSG_LEN = 15;

  localparam logic [7:0] CH_R     = 8'h52;
  localparam logic [7:0] CH_S     = 8'h53;
  localparam logic [7:0] CH_C     = 8'h43;
  localparam logic [7:0] CH_T     = 8'h54;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_ZERO  = 8'h30;

  // PC command bytes understood by stopwatch_cu
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_LAP  = 8'h4C;

endpackage

// File: rtl/bcd2ascii.sv
// Converts a 0..127 value into two ASCII decimal digits, saturating at 99.
module bcd2ascii
  import stopwatch_pkg::*;
(
  input  logic [6:0] value,
  output logic [7:0] tens,
  output logic [7:0] units
);

  logic [6:0] clamped;
  logic [6:0] tens_val;
  logic [6:0] units_val;

  always_comb begin
    clamped   = (value > 7'd99) ? 7'd99 : value;
    tens_val  = clamped / 7'd10;
    units_val = clamped % 7'd10;
    tens      = CH_ZERO + {1'b0, tens_val};
    units     = CH_ZERO + {1'b0, units_val};
  end

endmodule

// File: rtl/stopwatch_uart_reporter.sv
// Streams "<S> HH:MM:SS.CC\r\n" to uart_tx on run/stop edges, clear pulses and
// query bytes; the time is snapshotted once per line so bytes never tear.
module stopwatch_uart_reporter
  import stopwatch_pkg::*;
#(
  parameter logic [7:0] QUERY_CHAR = CH_T,
  parameter int         HOUR_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_stop,
  input  logic              clear,
  input  logic              rx_done,
  input  logic [7:0]        pc_data,
  input  logic [HOUR_W-1:0] hour,
  input  logic [5:0]        min,
  input  logic [5:0]        sec,
  input  logic [6:0]        msec,
  input  logic              tx_done,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              busy
);

  state_t     state_reg, state_next;
  logic       run_prev_reg;
  logic       pending_reg, pending_next;
  logic       clr_flag_reg, clr_flag_next;
  logic [3:0] idx_reg, idx_next;
  logic [7:0] status_reg;
  logic       load_en;
  logic       trigger;
  logic [7:0] byte_sel;

  logic [6:0] field_in [4];
  logic [7:0] tens_w   [4];
  logic [7:0] units_w  [4];

  assign trigger = (run_stop ^ run_prev_reg) | clear |
                   (rx_done & (pc_data == QUERY_CHAR));

  assign field_in[0] = 7'(hour);
  assign field_in[1] = {1'b0, min};
  assign field_in[2] = {1'b0, sec};
  assign field_in[3] = msec;

  // One frozen field plus its digit converter per time field
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_field
      logic [6:0] snap_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)          snap_reg <= '0;
        else if (load_en) snap_reg <= field_in[gi];
      end

      bcd2ascii u_bcd (
        .value (snap_reg),
        .tens  (tens_w[gi]),
        .units (units_w[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      run_prev_reg <= 1'b0;
      pending_reg  <= 1'b0;
      clr_flag_reg <= 1'b0;
      idx_reg      <= '0;
      status_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      run_prev_reg <= run_stop;
      pending_reg  <= pending_next;
      clr_flag_reg <= clr_flag_next;
      idx_reg      <= idx_next;
      if (load_en)
        status_reg <= clr_flag_reg ? CH_C : (run_stop ? CH_R : CH_S);
    end
  end

  // A trigger in the cycle it is seen already moves IDLE to LOAD, giving the
  // two-cycle trigger-to-tx_start latency.
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    pending_next  = pending_reg | trigger;
    clr_flag_next = clr_flag_reg | clear;
    load_en       = 1'b0;
    tx_start      = 1'b0;
    busy          = (state_reg != IDLE);
    case (state_reg)
      IDLE: if (pending_reg | trigger) state_next = LOAD;
      LOAD: begin
        load_en       = 1'b1;
        pending_next  = trigger;
        clr_flag_next = clear;
        idx_next      = '0;
        state_next    = SEND;
      end
      SEND: begin
        tx_start   = 1'b1;
        state_next = WAIT;
      end
      WAIT: if (tx_done) state_next = NEXT;
      NEXT: begin
        if (idx_reg == 4'(MSG_LEN - 1)) begin
          state_next = pending_reg ? LOAD : IDLE;
        end else begin
          idx_next   = idx_reg + 4'd1;
          state_next = SEND;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    byte_sel = 8'h00;
    case (idx_reg)
      4'd0:    byte_sel = status_reg;
      4'd1:    byte_sel = CH_SPACE;
      4'd2:    byte_sel = tens_w[0];
      4'd3:    byte_sel = units_w[0];
      4'd4:    byte_sel = CH_COLON;
      4'd5:    byte_sel = tens_w[1];
      4'd6:    byte_sel = units_w[1];
      4'd7:    byte_sel = CH_COLON;
      4'd8:    byte_sel = tens_w[2];
      4'd9:    byte_sel = units_w[2];
      4'd10:   byte_sel = CH_DOT;
      4'd11:   byte_sel = tens_w[3];
      4'd12:   byte_sel = units_w[3];
      4'd13:   byte_sel = CH_CR;
      4'd14:   byte_sel = CH_LF;
      default: byte_sel = 8'h00;
    endcase
  end

  // tx_data is only meaningful once the snapshot and index are settled
  assign tx_data = ((state_reg == SEND) || (state_reg == WAIT) || (state_reg == NEXT))
                   ? byte_sel : 8'h00;

endmodule
